// File: rtl/cnn_div_seq_23s_9s_pkg.sv
// Shared types and constants for the sequential signed divider.
package cnn_div_seq_23s_9s_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam int DividendWDef = 23;
  localparam int DivisorWDef  = 9;
  localparam int QuotWDef     = 14;

  // Saturation limits of the W14_6 quotient word.
  localparam int QUOT_MAX = (2 ** (QuotWDef - 1)) - 1;
  localparam int QUOT_MIN = -(2 ** (QuotWDef - 1));

endpackage

// File: rtl/cnn_div_seq_23s_9s_step.sv
// One restoring shift/subtract iteration on unsigned magnitudes.
module cnn_div_seq_23s_9s_step #(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 9
) (
  input  logic [DIVISOR_W-1:0]  rem_i,
  input  logic [DIVIDEND_W-1:0] quo_i,
  input  logic [DIVISOR_W-1:0]  div_i,
  output logic [DIVISOR_W-1:0]  rem_o,
  output logic [DIVIDEND_W-1:0] quo_o
);

  logic [DIVISOR_W:0]   trial;
  logic [DIVISOR_W-1:0] diff;
  logic                 ge;

  always_comb begin
    trial = {rem_i, quo_i[DIVIDEND_W-1]};
    ge    = (trial >= {1'b0, div_i});
    // When ge holds the difference is below the divisor, so the low bits suffice.
    diff  = trial[DIVISOR_W-1:0] - div_i;
    rem_o = ge ? diff : trial[DIVISOR_W-1:0];
    quo_o = {quo_i[DIVIDEND_W-2:0], ge};
  end

endmodule

// File: rtl/cnn_div_seq_23s_9s.sv
// Sequential signed divider: capture, DIVIDEND_W restoring steps, sign fix-up with saturation.
module cnn_div_seq_23s_9s
  import cnn_div_seq_23s_9s_pkg::*;
#(
  parameter int ID         = 1,
  parameter int DIVIDEND_W = DividendWDef,
  parameter int DIVISOR_W  = DivisorWDef,
  parameter int QUOT_W     = QuotWDef
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  input  logic signed [DIVIDEND_W-1:0] din0,
  input  logic signed [DIVISOR_W-1:0]  din1,
  output logic                         ap_idle,
  output logic                         ap_ready,
  output logic                         ap_done,
  output logic signed [QUOT_W-1:0]     quot,
  output logic signed [DIVISOR_W-1:0]  rem,
  output logic                         ovf,
  output logic                         dbz
);

  localparam int unsigned CntW = $clog2(DIVIDEND_W);
  localparam logic [QUOT_W-1:0] QMaxW = QUOT_W'(QUOT_MAX);
  localparam logic [QUOT_W-1:0] QMinW = QUOT_W'(QUOT_MIN);

  if (ID < 0) begin : g_id_tag
  end

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  remm_q, remm_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic                  sa_q, sa_d, sb_q, sb_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  ovf_q, ovf_d, dbz_q, dbz_d;

  logic [DIVIDEND_W-1:0] step_quo;
  logic [DIVISOR_W-1:0]  step_rem;
  logic [QUOT_W-1:0]     qlow;
  logic                  neg;

  cnn_div_seq_23s_9s_step #(
    .DIVIDEND_W(DIVIDEND_W),
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i(remm_q),
    .quo_i(quo_q),
    .div_i(div_q),
    .rem_o(step_rem),
    .quo_o(step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    remm_d  = remm_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    qlow    = quo_q[QUOT_W-1:0];
    neg     = sa_q ^ sb_q;

    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          state_d = StCalc;
          cnt_d   = CntW'(DIVIDEND_W - 1);
          sa_d    = din0[DIVIDEND_W-1];
          sb_d    = din1[DIVISOR_W-1];
          quo_d   = din0[DIVIDEND_W-1] ? (~din0) + DIVIDEND_W'(1) : din0;
          div_d   = din1[DIVISOR_W-1] ? (~din1) + DIVISOR_W'(1) : din1;
          remm_d  = '0;
        end
      end
      StCalc: begin
        quo_d  = step_quo;
        remm_d = step_rem;
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        state_d = StDone;
        if (div_q == '0) begin
          dbz_d  = 1'b1;
          ovf_d  = 1'b1;
          rem_d  = '0;
          quot_d = sa_q ? QMinW : QMaxW;
        end else begin
          dbz_d = 1'b0;
          rem_d = sa_q ? (~remm_q) + DIVISOR_W'(1) : remm_q;
          if (!neg && int'(quo_q) > QUOT_MAX) begin
            quot_d = QMaxW;
            ovf_d  = 1'b1;
          end else if (neg && int'(quo_q) > -QUOT_MIN) begin
            quot_d = QMinW;
            ovf_d  = 1'b1;
          end else begin
            quot_d = neg ? (~qlow) + QUOT_W'(1) : qlow;
            ovf_d  = 1'b0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      quo_q   <= '0;
      remm_q  <= '0;
      div_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      remm_q  <= remm_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ap_idle  = (state_q == StIdle);
  // Gated by reset so a start held during reset is not acknowledged.
  assign ap_ready = ap_idle & ap_start & ap_rst_n;
  assign ap_done  = (state_q == StDone);
  assign quot     = quot_q;
  assign rem      = rem_q;
  assign ovf      = ovf_q;
  assign dbz      = dbz_q;

endmodule

// File: tb/tb_cnn_div_seq_23s_9s.sv
// Directed bench for the sequential signed divider.
module tb_cnn_div_seq_23s_9s;

  logic               clk;
  logic               rst_n;
  logic               ap_start;
  logic signed [22:0] din0;
  logic signed [8:0]  din1;
  logic               ap_idle, ap_ready, ap_done;
  logic signed [13:0] quot;
  logic signed [8:0]  rem;
  logic               ovf, dbz;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int ovf;
    int dbz;
  } vec_t;

  vec_t vecs[20];

  cnn_div_seq_23s_9s #(
    .ID        (1),
    .DIVIDEND_W(23),
    .DIVISOR_W (9),
    .QUOT_W    (14)
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .ap_start(ap_start),
    .din0    (din0),
    .din1    (din1),
    .ap_idle (ap_idle),
    .ap_ready(ap_ready),
    .ap_done (ap_done),
    .quot    (quot),
    .rem     (rem),
    .ovf     (ovf),
    .dbz     (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Starts one divide and returns cycles from the start-sampling edge to ap_done (-1 on timeout).
  task automatic run_div(input int a, input int b, output int lat);
    bit seen;
    @(negedge clk);
    din0     = a[22:0];
    din1     = b[8:0];
    ap_start = 1'b1;
    #1 check("ap_ready_on_start", int'(ap_ready), 1);
    @(posedge clk);
    #1 ap_start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (lat < 100 && !seen) begin
      @(negedge clk);
      lat++;
      if (ap_done) seen = 1'b1;
    end
    if (!seen) lat = -1;
  endtask

  initial begin
    int lat;
    int n;
    int dones;
    int first_done;
    int second_done;
    int q_cap;
    int r_cap;

    vecs[0]  = '{1000, 7, 142, 6, 0, 0};
    vecs[1]  = '{-1000, 7, -142, -6, 0, 0};
    vecs[2]  = '{1000, -7, -142, 6, 0, 0};
    vecs[3]  = '{-1000, -7, 142, -6, 0, 0};
    vecs[4]  = '{100000, 3, 8191, 1, 1, 0};
    vecs[5]  = '{-4194304, -1, 8191, 0, 1, 0};
    vecs[6]  = '{-5, 0, -8192, 0, 1, 1};
    vecs[7]  = '{5, 0, 8191, 0, 1, 1};
    vecs[8]  = '{0, 0, 8191, 0, 1, 1};
    vecs[9]  = '{8191, 1, 8191, 0, 0, 0};
    vecs[10] = '{-8192, 1, -8192, 0, 0, 0};
    vecs[11] = '{8192, 1, 8191, 0, 1, 0};
    vecs[12] = '{-8193, 1, -8192, 0, 1, 0};
    vecs[13] = '{4194303, -256, -8192, 255, 1, 0};
    vecs[14] = '{-4194304, -256, 8191, 0, 1, 0};
    vecs[15] = '{1000, -256, -3, 232, 0, 0};
    vecs[16] = '{-1000, 256 - 512, 3, -232, 0, 0};
    vecs[17] = '{6, 7, 0, 6, 0, 0};
    vecs[18] = '{-6, 7, 0, -6, 0, 0};
    vecs[19] = '{0, 5, 0, 0, 0, 0};

    rst_n    = 1'b0;
    ap_start = 1'b1;
    din0     = 23'sd1000;
    din1     = 9'sd7;
    repeat (3) @(negedge clk);
    check("rst_idle", int'(ap_idle), 1);
    check("rst_ready", int'(ap_ready), 0);
    check("rst_done", int'(ap_done), 0);
    check("rst_quot", int'(quot), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dbz", int'(dbz), 0);
    ap_start = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, 25);
      check($sformatf("v%0d_quot", i), int'(quot), vecs[i].q);
      check($sformatf("v%0d_rem", i), int'(rem), vecs[i].r);
      check($sformatf("v%0d_ovf", i), int'(ovf), vecs[i].ovf);
      check($sformatf("v%0d_dbz", i), int'(dbz), vecs[i].dbz);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), int'(ap_done), 0);
      check($sformatf("v%0d_quot_hold", i), int'(quot), vecs[i].q);
    end

    // Second start during CALC plus operand change must be ignored.
    @(negedge clk);
    din0 = 23'sd1000; din1 = 9'sd7; ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    dones = 0; first_done = -1; q_cap = 0; r_cap = 0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ap_done) begin
        dones++;
        if (first_done < 0) begin
          first_done = n; q_cap = int'(quot); r_cap = int'(rem);
        end
      end
      if (n == 10) begin
        din0 = 23'sd5; din1 = 9'sd1; ap_start = 1'b1;
        #1 check("ign_ready_in_calc", int'(ap_ready), 0);
      end
      if (n == 11) ap_start = 1'b0;
    end
    check("ign_done_count", dones, 1);
    check("ign_done_cycle", first_done, 25);
    check("ign_quot", q_cap, 142);
    check("ign_rem", r_cap, 6);

    // Start held high: back-to-back results.
    @(negedge clk);
    din0 = 23'sd1000; din1 = 9'sd7; ap_start = 1'b1;
    @(posedge clk);
    dones = 0; first_done = -1; second_done = -1;
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ap_done) begin
        dones++;
        if (first_done < 0) first_done = n;
        else if (second_done < 0) begin
          second_done = n;
          ap_start = 1'b0;
        end
      end
    end
    ap_start = 1'b0;
    check("held_done_count", dones, 2);
    check("held_first_done", first_done, 25);
    check("held_second_done", second_done, 51);
    check("held_quot", int'(quot), 142);

    // Leave nonzero results behind, then reset in the middle of CALC.
    run_div(-5, 0, lat);
    check("pre_rst_dbz", int'(dbz), 1);
    @(negedge clk);
    din0 = 23'sd1000; din1 = 9'sd7; ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    for (n = 1; n <= 12; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_idle", int'(ap_idle), 1);
    check("midrst_done", int'(ap_done), 0);
    check("midrst_quot", int'(quot), 0);
    check("midrst_rem", int'(rem), 0);
    check("midrst_ovf", int'(ovf), 0);
    check("midrst_dbz", int'(dbz), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ap_done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_div(-1000, 7, lat);
    check("post_rst_latency", lat, 25);
    check("post_rst_quot", int'(quot), -142);
    check("post_rst_rem", int'(rem), -6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_div_seq_23s_9s.md
CNN_DIV_SEQ_23S_9S -- requirements
Module: cnn_div_seq_23s_9s

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter DIVIDEND_W, default 23, signed dividend width.
REQ-003 SHALL have parameter DIVISOR_W, default 9, signed divisor width.
REQ-004 SHALL have parameter QUOT_W, default 14, signed quotient width (W14_6 fixed-point word).
REQ-005 SHALL have port ap_clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port ap_rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port ap_start, input, 1, request to start a divide.
REQ-008 SHALL have port din0, input, DIVIDEND_W, signed dividend (product-width operand).
REQ-009 SHALL have port din1, input, DIVISOR_W, signed divisor.
REQ-010 SHALL have port ap_idle, output, 1, high when in IDLE.
REQ-011 SHALL have port ap_ready, output, 1, one-cycle pulse when operands are captured.
REQ-012 SHALL have port ap_done, output, 1, one-cycle pulse when results are valid.
REQ-013 SHALL have port quot, output, QUOT_W, signed saturated quotient.
REQ-014 SHALL have port rem, output, DIVISOR_W, signed remainder.
REQ-015 SHALL have port ovf, output, 1, quotient saturated or divide-by-zero.
REQ-016 SHALL have port dbz, output, 1, divisor was zero.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-018 IDLE: when ap_start=1, SHALL capture din0/din1, assert ap_ready that cycle, and enter CALC.
REQ-019 SHALL capture operand signs and unsigned magnitudes; |-2^22|=2^22 and |-256|=256 are representable without loss.
REQ-020 CALC: SHALL run one restoring shift/subtract step per cycle for exactly DIVIDEND_W cycles, counted by a down-counter.
REQ-021 FIX: SHALL apply signs, with quotient truncated toward zero and remainder carrying the dividend's sign (C semantics), then saturate.
REQ-022 Saturation: a true quotient > 2^(QUOT_W-1)-1 SHALL yield 8191 and a true quotient < -2^(QUOT_W-1) SHALL yield -8192; either case SHALL set ovf=1.
REQ-023 Divisor zero: SHALL set dbz=1 and ovf=1, rem=0, and quot=8191 if dividend>=0, else -8192.
REQ-024 DONE: SHALL assert ap_done for one cycle, then return to IDLE.
REQ-025 Latency: ap_done SHALL be high exactly DIVIDEND_W+2 cycles (25 by default) after the cycle in which ap_start was sampled in IDLE.
REQ-026 quot/rem/ovf/dbz SHALL be registered and SHALL hold their values from ap_done until the next ap_done.
REQ-027 ap_start outside IDLE SHALL be ignored; there is no queuing.
REQ-028 ap_start held high SHALL start a new divide on the cycle after DONE, i.e. back-to-back throughput of one result per 26 cycles.
REQ-029 din0/din1 changes after capture SHALL NOT affect the result.

Reset
REQ-030 ap_rst_n=0 SHALL asynchronously force IDLE and clear the counter and all datapath registers.
REQ-031 During reset, outputs SHALL be ap_idle=1, ap_ready=0, ap_done=0, quot=0, rem=0, ovf=0, dbz=0.
REQ-032 Reset asserted mid-CALC SHALL abort the operation; no ap_done SHALL follow.
REQ-033 Reset deassertion SHALL take effect on the next rising edge; the first start is accepted on that edge or later.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, default widths, and the QUOT_MAX/QUOT_MIN saturation constants.
REQ-035 One sub-module, cnn_div_seq_23s_9s_step, SHALL hold the combinational single-iteration restoring step; the top instantiates it once.
REQ-036 The block SHALL use no DSP primitives and no multipliers.

Verification
REQ-037 din0=1000, din1=7 -> quot=142, rem=6, ovf=0; ap_done exactly 25 cycles after start.
REQ-038 din0=-1000, din1=7 -> quot=-142, rem=-6; din0=1000, din1=-7 -> quot=-142, rem=6.
REQ-039 din0=100000, din1=3 -> quot=8191, ovf=1; din0=-4194304, din1=-1 -> quot=8191, ovf=1.
REQ-040 din0=-5, din1=0 -> dbz=1, ovf=1, quot=-8192, rem=0.
REQ-041 ap_start pulsed again at cycle 10 of a divide -> ignored, single ap_done; ap_start held high -> ap_done at cycles 25 and 51.
REQ-042 ap_rst_n low at cycle 12 of CALC -> immediate IDLE, outputs zero, no ap_done; a new divide then completes correctly.
